// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and payload layout for the inter-stage pipeline register.
// Default payload is the E/M bundle {cmp, alu, mem}.
package pipe_stage_reg_pkg;

  localparam logic [31:0] DEF_NOP_INSTR = 32'd0;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  localparam int MEM_W   = 32;
  localparam int ALU_W   = 32;
  localparam int CMP_W   = 1;
  localparam int ALU_OFF = MEM_W;
  localparam int CMP_OFF = ALU_OFF + ALU_W;
  localparam int EX_DATA_W = CMP_OFF + CMP_W;

  function automatic logic [EX_DATA_W-1:0] pack_ex(
    input logic [CMP_W-1:0] cmp,
    input logic [ALU_W-1:0] alu,
    input logic [MEM_W-1:0] mem
  );
    return {cmp, alu, mem};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle between pipeline stages.
// master drives the entry, slave answers with ready.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DATA_W  = EX_DATA_W
);

  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc8;
  logic [DATA_W-1:0]  data;

  modport master (
    output valid, instr, pc8, data,
    input  ready
  );

  modport slave (
    input  valid, instr, pc8, data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One held pipeline entry: valid flag plus instr/pc8/data.
// Clear beats load so a flush always empties the slot.
module pipe_slot #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 65
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               ld_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc8_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc8_o,
  output logic [DATA_W-1:0]  data_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc8_q;
  logic [DATA_W-1:0]  data_q;

  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc8_q   <= '0;
      data_q  <= '0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc8_q   <= pc8_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc8_o   = pc8_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush and bubble-to-NOP.
// SKID=1 adds a second slot so in_ready comes straight from a flop.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               INSTR_W   = 32,
  parameter int               PC_W      = 32,
  parameter int               DATA_W    = EX_DATA_W,
  parameter bit               SKID      = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  pipe_stage_reg_if.slave         in_if,
  pipe_stage_reg_if.master        out_if,
  output logic [1:0]              occupancy_o
);

  state_e state_q, state_d;

  logic accept, consume;
  logic main_ld, main_clr;
  logic skid_ld, skid_clr;
  logic from_skid;

  logic               main_v, skid_v;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_instr_d;
  logic [PC_W-1:0]    main_pc8, skid_pc8, main_pc8_d;
  logic [DATA_W-1:0]  main_data, skid_data, main_data_d;

  assign accept  = in_if.valid & in_if.ready;
  assign consume = main_v & out_if.ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    main_ld   = 1'b0;
    main_clr  = 1'b0;
    skid_ld   = 1'b0;
    skid_clr  = 1'b0;
    from_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_ld = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_ld = 1'b1;
        end else if (accept && SKID) begin
          skid_ld = 1'b1;
          state_d = ST_TWO;
        end else if (consume) begin
          main_clr = 1'b1;
          state_d  = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          main_ld   = 1'b1;
          from_skid = 1'b1;
          skid_clr  = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides any same-cycle accept or consume.
    if (flush_i) begin
      state_d   = ST_EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
      from_skid = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  assign main_instr_d = from_skid ? skid_instr : in_if.instr;
  assign main_pc8_d   = from_skid ? skid_pc8   : in_if.pc8;
  assign main_data_d  = from_skid ? skid_data  : in_if.data;

  pipe_slot #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .DATA_W  (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst_i   (reset),
    .clr_i   (main_clr),
    .ld_i    (main_ld),
    .instr_i (main_instr_d),
    .pc8_i   (main_pc8_d),
    .data_i  (main_data_d),
    .valid_o (main_v),
    .instr_o (main_instr),
    .pc8_o   (main_pc8),
    .data_o  (main_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .INSTR_W (INSTR_W),
      .PC_W    (PC_W),
      .DATA_W  (DATA_W)
    ) u_skid (
      .clk     (clk),
      .rst_i   (reset),
      .clr_i   (skid_clr),
      .ld_i    (skid_ld),
      .instr_i (in_if.instr),
      .pc8_i   (in_if.pc8),
      .data_i  (in_if.data),
      .valid_o (skid_v),
      .instr_o (skid_instr),
      .pc8_o   (skid_pc8),
      .data_o  (skid_data)
    );
    assign in_if.ready = (state_q != ST_TWO);
  end else begin : g_noskid
    logic unused_skid;
    assign unused_skid = skid_ld | skid_clr;
    assign skid_v      = 1'b0;
    assign skid_instr  = '0;
    assign skid_pc8    = '0;
    assign skid_data   = '0;
    assign in_if.ready = !main_v | out_if.ready;
  end

  assign occupancy_o = {1'b0, main_v} + {1'b0, skid_v};

  assign out_if.valid = main_v;
  assign out_if.instr = main_v ? main_instr : NOP_INSTR;
  assign out_if.pc8   = main_v ? main_pc8   : '0;
  assign out_if.data  = main_v ? main_data  : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 side by side,
// directed scenarios then random traffic against queue models.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int IW = 32;
  localparam int PW = 32;
  localparam int DW = EX_DATA_W;
  localparam logic [IW-1:0] NOP0 = '0;
  localparam logic [IW-1:0] NOP1 = 32'h0000_0013;

  typedef struct packed {
    logic [IW-1:0] i;
    logic [PW-1:0] p;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          v = 1'b0;
  logic          ordy = 1'b0;
  logic [IW-1:0] instr = '0;
  logic [PW-1:0] pc8 = '0;
  logic [DW-1:0] data = '0;
  logic [1:0]    occ0, occ1;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t q0[$];
  ent_t q1[$];

  pipe_stage_reg_if #(.INSTR_W(IW), .PC_W(PW), .DATA_W(DW)) in0 ();
  pipe_stage_reg_if #(.INSTR_W(IW), .PC_W(PW), .DATA_W(DW)) out0 ();
  pipe_stage_reg_if #(.INSTR_W(IW), .PC_W(PW), .DATA_W(DW)) in1 ();
  pipe_stage_reg_if #(.INSTR_W(IW), .PC_W(PW), .DATA_W(DW)) out1 ();

  assign in0.valid  = v;
  assign in0.instr  = instr;
  assign in0.pc8    = pc8;
  assign in0.data   = data;
  assign out0.ready = ordy;
  assign in1.valid  = v;
  assign in1.instr  = instr;
  assign in1.pc8    = pc8;
  assign in1.data   = data;
  assign out1.ready = ordy;

  pipe_stage_reg #(
    .INSTR_W(IW), .PC_W(PW), .DATA_W(DW),
    .SKID(1'b0), .NOP_INSTR(NOP0)
  ) d0 (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_if       (in0),
    .out_if      (out0),
    .occupancy_o (occ0)
  );

  pipe_stage_reg #(
    .INSTR_W(IW), .PC_W(PW), .DATA_W(DW),
    .SKID(1'b1), .NOP_INSTR(NOP1)
  ) d1 (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_if       (in1),
    .out_if      (out1),
    .occupancy_o (occ1)
  );

  // Reference: a stage is a FIFO of depth 1 (SKID=0) or 2 (SKID=1).
  task automatic tick();
    logic a0, a1, c0, c1;
    ent_t e;
    e  = {instr, pc8, data};
    a0 = v && (q0.size() == 0 || ordy);
    a1 = v && (q1.size() < 2);
    c0 = (q0.size() > 0) && ordy;
    c1 = (q1.size() > 0) && ordy;
    @(posedge clk);
    if (reset || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(e);
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic rand_payload();
    pc8  = $urandom;
    data = pack_ex(1'($urandom), $urandom, $urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; v = 1'b0; ordy = 1'b0; flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (out0.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", out0.valid); end
    n_tests++;
    if (out1.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b want 0", out1.valid); end
    n_tests++;
    if (out0.instr !== NOP0) begin n_fail++; $display("FAIL reset_instr0: got %h want %h", out0.instr, NOP0); end
    n_tests++;
    if (out1.instr !== NOP1) begin n_fail++; $display("FAIL reset_instr1: got %h want %h", out1.instr, NOP1); end
    n_tests++;
    if (in0.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b want 1", in0.ready); end
    n_tests++;
    if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b want 1", in1.ready); end
    n_tests++;
    if (occ0 !== 2'd0) begin n_fail++; $display("FAIL reset_occ0: got %0d want 0", occ0); end
    n_tests++;
    if (occ1 !== 2'd0) begin n_fail++; $display("FAIL reset_occ1: got %0d want 0", occ1); end
  endtask

  task automatic test_stream();
    logic [PW-1:0] sp;
    logic [DW-1:0] sd;
    ordy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      v = 1'b1;
      instr = IW'(k);
      rand_payload();
      sp = pc8;
      sd = data;
      #1;
      n_tests++;
      if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready1 k=%0d: got %b want 1", k, in1.ready); end
      tick();
      n_tests++;
      if (out0.valid !== 1'b1 || out0.instr !== IW'(k)) begin
        n_fail++; $display("FAIL stream0 k=%0d: got v=%b i=%h want v=1 i=%h", k, out0.valid, out0.instr, k);
      end
      n_tests++;
      if (out1.valid !== 1'b1 || out1.instr !== IW'(k)) begin
        n_fail++; $display("FAIL stream1 k=%0d: got v=%b i=%h want v=1 i=%h", k, out1.valid, out1.instr, k);
      end
      n_tests++;
      if (out1.pc8 !== sp || out1.data !== sd) begin
        n_fail++; $display("FAIL stream1_payload k=%0d: got %h/%h want %h/%h", k, out1.pc8, out1.data, sp, sd);
      end
    end
    v = 1'b0;
    tick();
    n_tests++;
    if (out0.valid !== 1'b0 || out1.valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain: got %b/%b want 0/0", out0.valid, out1.valid);
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] got[$];
    logic took;
    ordy = 1'b0;
    v = 1'b1; instr = 32'hA; rand_payload();
    tick();
    n_tests++;
    if (occ1 !== 2'd1 || in1.ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_A: got occ=%0d rdy=%b want occ=1 rdy=1", occ1, in1.ready);
    end
    instr = 32'hB; rand_payload();
    tick();
    n_tests++;
    if (occ1 !== 2'd2 || in1.ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_B: got occ=%0d rdy=%b want occ=2 rdy=0", occ1, in1.ready);
    end
    instr = 32'hC; rand_payload();
    tick();
    n_tests++;
    if (occ1 !== 2'd2 || out1.instr !== 32'hA) begin
      n_fail++; $display("FAIL stall_hold: got occ=%0d i=%h want occ=2 i=a", occ1, out1.instr);
    end
    ordy = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (out1.valid) got.push_back(out1.instr);
      took = v && in1.ready;
      tick();
      if (took) v = 1'b0;
    end
    n_tests++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL stall_count: got %0d entries want 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_tests++;
        if (got[j] !== IW'(32'hA + j)) begin
          n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", j, got[j], 32'hA + j);
        end
      end
    end
  endtask

  task automatic test_flush();
    ordy = 1'b0;
    v = 1'b1; instr = 32'h11; rand_payload();
    tick();
    instr = 32'h12; rand_payload();
    tick();
    n_tests++;
    if (occ1 !== 2'd2) begin n_fail++; $display("FAIL flush_fill: got occ=%0d want 2", occ1); end
    flush = 1'b1; instr = 32'hD; rand_payload();
    tick();
    flush = 1'b0; v = 1'b0;
    n_tests++;
    if (out1.valid !== 1'b0 || occ1 !== 2'd0 || occ0 !== 2'd0) begin
      n_fail++; $display("FAIL flush_empty: got v=%b occ1=%0d occ0=%0d want 0/0/0", out1.valid, occ1, occ0);
    end
    n_tests++;
    if (out1.instr !== NOP1 || out1.pc8 !== '0 || out1.data !== '0) begin
      n_fail++; $display("FAIL flush_bubble: got %h/%h/%h want %h/0/0", out1.instr, out1.pc8, out1.data, NOP1);
    end
    ordy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (out1.valid !== 1'b0 || out0.valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_ghost c=%0d: got %b/%b i=%h want 0/0", c, out0.valid, out1.valid, out1.instr);
      end
    end
  endtask

  task automatic test_reset_mid();
    ordy = 1'b0;
    v = 1'b1; instr = 32'h21; rand_payload();
    tick();
    instr = 32'h22;
    tick();
    n_tests++;
    if (occ1 !== 2'd2) begin n_fail++; $display("FAIL rstmid_fill: got occ=%0d want 2", occ1); end
    reset = 1'b1; v = 1'b0;
    tick();
    reset = 1'b0;
    n_tests++;
    if (occ1 !== 2'd0 || out1.valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_empty: got occ=%0d v=%b want 0/0", occ1, out1.valid);
    end
    v = 1'b1; instr = 32'hE; ordy = 1'b1; rand_payload();
    tick();
    v = 1'b0;
    n_tests++;
    if (out1.instr !== 32'hE || occ1 !== 2'd1 || out0.instr !== 32'hE) begin
      n_fail++; $display("FAIL rstmid_E: got %h occ=%0d d0=%h want e/1/e", out1.instr, occ1, out0.instr);
    end
    tick();
    n_tests++;
    if (out1.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_alone: got v=%b i=%h want 0", out1.valid, out1.instr); end
  endtask

  task automatic test_random();
    logic          hold;
    logic [IW-1:0] pi;
    logic [PW-1:0] pp;
    logic [DW-1:0] pd;
    ent_t          e0, e1;
    logic          ev0, ev1, er0, er1;
    hold = 1'b0; pi = '0; pp = '0; pd = '0;
    for (int c = 0; c < 10000; c++) begin
      v     = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 499) == 0);
      instr = $urandom;
      rand_payload();
      #1;
      ev0 = q0.size() > 0;
      ev1 = q1.size() > 0;
      e0  = ev0 ? q0[0] : {NOP0, PW'(0), DW'(0)};
      e1  = ev1 ? q1[0] : {NOP1, PW'(0), DW'(0)};
      er0 = (q0.size() == 0) || ordy;
      er1 = q1.size() < 2;
      n_tests++;
      if ({out0.valid, out0.instr, out0.pc8, out0.data, occ0, in0.ready} !==
          {ev0, e0.i, e0.p, e0.d, 2'(q0.size()), er0}) begin
        n_fail++;
        $display("FAIL rand0 c=%0d: got v=%b i=%h occ=%0d r=%b want v=%b i=%h occ=%0d r=%b",
                 c, out0.valid, out0.instr, occ0, in0.ready, ev0, e0.i, q0.size(), er0);
      end
      n_tests++;
      if ({out1.valid, out1.instr, out1.pc8, out1.data, occ1, in1.ready} !==
          {ev1, e1.i, e1.p, e1.d, 2'(q1.size()), er1}) begin
        n_fail++;
        $display("FAIL rand1 c=%0d: got v=%b i=%h occ=%0d r=%b want v=%b i=%h occ=%0d r=%b",
                 c, out1.valid, out1.instr, occ1, in1.ready, ev1, e1.i, q1.size(), er1);
      end
      if (hold) begin
        n_tests++;
        if (out1.instr !== pi || out1.pc8 !== pp || out1.data !== pd) begin
          n_fail++; $display("FAIL rand_stable c=%0d: got %h want %h", c, out1.instr, pi);
        end
      end
      hold = out1.valid && !ordy && !flush && !reset;
      pi = out1.instr; pp = out1.pc8; pd = out1.data;
      tick();
    end
    reset = 1'b0; flush = 1'b0; v = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
